// File: rtl/hazard_scheduler.sv
// Pipeline hazard sequencer for the 5-stage core.
// It handles load-use stalls, EX redirects and dmem wait states, and drives the
// stage-register enables, flushes and bubbles. It also drives the EX forwarding selects,
// a stall-cycle counter and a sticky dmem-timeout flag.
module hazard_scheduler #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cycles,
    output logic        halt_err
);

    typedef enum logic [1:0] {StRun, StLuStall, StMemWait, StHalt} state_e;

    localparam logic [2:0] LuInit  = 3'(LOAD_LAT - 1);
    localparam logic [7:0] WaitMax = 8'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [2:0]  lu_cnt_q, lu_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_q;
    logic        halt_q, halt_d;

    logic hz_lu, freeze;
    logic pc_we_c, ifid_we_c, idex_we_c, exmem_we_c;
    logic ifid_flush_c, idex_bubble_c, memwb_bubble_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign hz_lu  = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign freeze = dmem_req & ~dmem_ready;

    // Next-state and stage controls, in priority order HALT > freeze > redirect > load-use.
    always_comb begin
        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        halt_d         = halt_q;
        pc_we_c        = 1'b1;
        ifid_we_c      = 1'b1;
        idex_we_c      = 1'b1;
        exmem_we_c     = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        memwb_bubble_c = 1'b0;
        if (state_q == StHalt) begin
            pc_we_c        = 1'b0;
            ifid_we_c      = 1'b0;
            idex_we_c      = 1'b0;
            exmem_we_c     = 1'b0;
            ifid_flush_c   = 1'b1;
            idex_bubble_c  = 1'b1;
            memwb_bubble_c = 1'b1;
        end else if (freeze) begin
            pc_we_c        = 1'b0;
            ifid_we_c      = 1'b0;
            idex_we_c      = 1'b0;
            exmem_we_c     = 1'b0;
            memwb_bubble_c = 1'b1;
            if (state_q == StMemWait) begin
                if (wait_cnt_q == WaitMax) begin
                    state_d = StHalt;
                    halt_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end else begin
                // lu_cnt is held so an interrupted load-use stall resumes afterwards
                state_d    = StMemWait;
                wait_cnt_d = 8'd1;
            end
        end else if (state_q == StMemWait) begin
            wait_cnt_d = 8'd0;
            if (ex_redirect) begin
                // the instruction owed a load-use stall is squashed along with ID
                ifid_flush_c  = 1'b1;
                idex_bubble_c = 1'b1;
                lu_cnt_d      = 3'd0;
                state_d       = StRun;
            end else begin
                state_d = (lu_cnt_q != 3'd0) ? StLuStall : StRun;
            end
        end else if (ex_redirect) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            lu_cnt_d      = 3'd0;
            state_d       = StRun;
        end else if (state_q == StLuStall) begin
            pc_we_c       = 1'b0;
            ifid_we_c     = 1'b0;
            idex_bubble_c = 1'b1;
            lu_cnt_d      = lu_cnt_q - 3'd1;
            if (lu_cnt_q == 3'd1) begin
                state_d = StRun;
            end
        end else if (hz_lu) begin
            pc_we_c       = 1'b0;
            ifid_we_c     = 1'b0;
            idex_bubble_c = 1'b1;
            lu_cnt_d      = LuInit;
            state_d       = (LOAD_LAT > 1) ? StLuStall : StRun;
        end
    end

    // Forwarding selects: EX/MEM wins over MEM/WB, x0 never forwarded.
    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) begin
            fwd_a_c = 2'b10;
        end else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1) begin
            fwd_a_c = 2'b01;
        end
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) begin
            fwd_b_c = 2'b10;
        end else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2) begin
            fwd_b_c = 2'b01;
        end
    end

    // Outputs take their safe values combinationally while reset is asserted.
    always_comb begin
        pc_we        = pc_we_c;
        ifid_we      = ifid_we_c;
        idex_we      = idex_we_c;
        exmem_we     = exmem_we_c;
        ifid_flush   = ifid_flush_c;
        idex_bubble  = idex_bubble_c;
        memwb_bubble = memwb_bubble_c;
        fwd_a        = fwd_a_c;
        fwd_b        = fwd_b_c;
        if (!rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
        end
    end

    assign stall_cycles = stall_q;
    assign halt_err     = halt_q;

    // State, counters and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            lu_cnt_q   <= 3'd0;
            wait_cnt_q <= 8'd0;
            stall_q    <= 32'd0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            halt_q     <= halt_d;
            if (!pc_we_c) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: two instances (LOAD_LAT=1/MAX_WAIT=5 and LOAD_LAT=3/MAX_WAIT=8)
// share one stimulus stream and are compared every cycle against a stall-accounting model.
module tb_hazard_scheduler;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_mem_read, ex_redirect, mem_reg_write, wb_reg_write, dmem_req, dmem_ready;

    logic [1:0]  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble;
    logic [1:0]  halt_err;
    logic [1:0]  fwd_a [2];
    logic [1:0]  fwd_b [2];
    logic [31:0] stall_cycles [2];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model per instance
    int          lat   [2] = '{1, 3};
    int          mw    [2] = '{5, 8};
    int          owed  [2];
    int          frz   [2];
    bit          halted[2];
    logic [31:0] stalls[2];

    hazard_scheduler #(.LOAD_LAT(1), .MAX_WAIT(5)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_we(pc_we[0]), .ifid_we(ifid_we[0]),
        .idex_we(idex_we[0]), .exmem_we(exmem_we[0]), .ifid_flush(ifid_flush[0]),
        .idex_bubble(idex_bubble[0]), .memwb_bubble(memwb_bubble[0]), .fwd_a(fwd_a[0]),
        .fwd_b(fwd_b[0]), .stall_cycles(stall_cycles[0]), .halt_err(halt_err[0])
    );

    hazard_scheduler #(.LOAD_LAT(3), .MAX_WAIT(8)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_we(pc_we[1]), .ifid_we(ifid_we[1]),
        .idex_we(idex_we[1]), .exmem_we(exmem_we[1]), .ifid_flush(ifid_flush[1]),
        .idex_bubble(idex_bubble[1]), .memwb_bubble(memwb_bubble[1]), .fwd_a(fwd_a[1]),
        .fwd_b(fwd_b[1]), .stall_cycles(stall_cycles[1]), .halt_err(halt_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hz_lu();
        return id_valid && ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble}
    function automatic logic [6:0] ctrl_exp(input int k);
        bit frozen;
        frozen = dmem_req && !dmem_ready;
        if (!rst || halted[k])  return 7'b0000111;
        if (frozen)             return 7'b0000001;
        if (ex_redirect)        return 7'b1111110;
        if (frz[k] > 0)         return 7'b1111000;  // wait released: advance this cycle
        if (owed[k] > 0 || hz_lu()) return 7'b0011010;
        return 7'b1111000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0; frz[k] = 0; halted[k] = 1'b0; stalls[k] = 32'd0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [6:0] act;
        for (int k = 0; k < 2; k++) begin
            act = {pc_we[k], ifid_we[k], idex_we[k], exmem_we[k], ifid_flush[k],
                   idex_bubble[k], memwb_bubble[k]};
            check($sformatf("%s.ctrl%0d", tag, k), 32'(act), 32'(ctrl_exp(k)));
            check($sformatf("%s.fwd%0d", tag, k), {28'd0, fwd_a[k], fwd_b[k]},
                  rst ? {28'd0, fwd_exp(ex_rs1), fwd_exp(ex_rs2)} : 32'd0);
            check($sformatf("%s.halt%0d", tag, k), 32'(halt_err[k]), 32'(halted[k]));
            check($sformatf("%s.stall%0d", tag, k), stall_cycles[k], stalls[k]);
        end
    endtask

    // Advance the model across the coming clock edge.
    task automatic model_step();
        bit frozen;
        frozen = dmem_req && !dmem_ready;
        if (!rst) return;
        for (int k = 0; k < 2; k++) begin
            if (ctrl_exp(k)[6] == 1'b0) stalls[k] = stalls[k] + 32'd1;
            if (halted[k]) begin
                // held until reset
            end else if (frozen) begin
                frz[k]++;
                if (frz[k] > mw[k]) halted[k] = 1'b1;
            end else if (frz[k] > 0) begin
                frz[k] = 0;
                if (ex_redirect) owed[k] = 0;
            end else if (ex_redirect) begin
                owed[k] = 0;
            end else if (owed[k] > 0) begin
                owed[k]--;
            end else if (hz_lu()) begin
                owed[k] = lat[k] - 1;
            end
        end
    endtask

    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; mem_reg_write = 1'b0;
        mem_rd = 5'd0; wb_reg_write = 1'b0; wb_rd = 5'd0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_lw_hazard();
        id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd5;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();

        // load-use hazard for one cycle, then drained
        set_lw_hazard();
        cyc("lu_hit");
        ex_mem_read = 1'b0;
        for (int i = 0; i < 4; i++) cyc("lu_drain");

        // ex_rd = x0 never stalls
        set_lw_hazard();
        ex_rd = 5'd0; id_rs2 = 5'd0;
        cyc("lu_x0");
        idle_inputs();
        cyc("lu_x0_after");

        // redirect with simultaneous hazard: squash, no stall
        set_lw_hazard();
        ex_redirect = 1'b1;
        cyc("redir_lu");
        idle_inputs();
        cyc("redir_after");

        // freeze for 4 cycles in the middle of a load-use stall
        set_lw_hazard();
        cyc("lu_start");
        idle_inputs();
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc("freeze");
        dmem_ready = 1'b1;
        cyc("release");
        idle_inputs();
        for (int i = 0; i < 4; i++) cyc("lu_resume");

        // forwarding priority and x0
        mem_reg_write = 1'b1; wb_reg_write = 1'b1; mem_rd = 5'd7; wb_rd = 5'd7;
        ex_rs1 = 5'd7; ex_rs2 = 5'd3;
        cyc("fwd_mem");
        mem_reg_write = 1'b0;
        cyc("fwd_wb");
        mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        cyc("fwd_x0");
        idle_inputs();

        // randomized traffic with periodic reset
        for (int n = 0; n < 1500; n++) begin
            if (n % 400 == 399) begin
                idle_inputs();
                do_reset();
            end
            id_valid      = $urandom_range(0, 3) != 0;
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rs1        = 5'($urandom_range(0, 3));
            ex_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            mem_rd        = 5'($urandom_range(0, 3));
            wb_rd         = 5'($urandom_range(0, 3));
            ex_mem_read   = $urandom_range(0, 2) == 0;
            ex_redirect   = $urandom_range(0, 9) == 0;
            mem_reg_write = $urandom_range(0, 1) == 1;
            wb_reg_write  = $urandom_range(0, 1) == 1;
            dmem_req      = $urandom_range(0, 4) == 0;
            dmem_ready    = $urandom_range(0, 1) == 1;
            cyc("rand");
        end
        idle_inputs();
        do_reset();

        // dmem never ready: both instances time out and stay halted
        dmem_req = 1'b1;
        for (int i = 0; i < 12; i++) cyc("timeout");
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc("halt_hold");
        idle_inputs();
        do_reset();

        // asynchronous reset in the middle of a dmem wait
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("wait_pre");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        cyc("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
